uart_tx_fifo: RTL

//  Memory-mapped UART transmit peripheral downstream of the address decoder. It consumes core store/load

---
 rtl/uart_tx_fifo_pkg.sv | 21 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared register offsets, STATUS bit positions and serialiser states for the UART transmitter.
// Types and constants only; no logic, latency or flow control.
package uart_tx_fifo_pkg;

  localparam logic [1:0] UART_TXDATA_OFF = 2'd0;
  localparam logic [1:0] UART_STATUS_OFF = 2'd1;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_CNT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Byte FIFO with first-word-fall-through read data; pushes become visible one cycle later.
// A push while full is accepted only when a pop happens on the same edge; otherwise it is dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // When full, wr_ptr equals rd_ptr: the head is read out before the edge overwrites it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a byte FIFO, STATUS reports state, reads return one cycle later.
// Never stalls the core: stores into a full FIFO are dropped and flagged in the sticky overflow bit.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_en,
  input  logic [XLEN-1:0] uart_addr,
  input  logic            mem_wr_en,
  input  logic            mem_rd_en,
  input  logic [XLEN-1:0] mem_wr_data,
  output logic [XLEN-1:0] mem_rd_data,
  output logic            uart_tx,
  output logic            tx_busy,
  output logic            fifo_full
);

  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

  logic [1:0]       reg_off;
  logic             push, pop, stat_wr, ovf_set;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic [XLEN-1:0]  status_word;
  logic             unused_bits;

  tx_state_e        state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic [XLEN-1:0]  rd_q, rd_d;

  assign unused_bits = ^{uart_addr[XLEN-1:4], uart_addr[1:0], mem_wr_data[XLEN-1:8]};

  assign reg_off = uart_addr[3:2];
  assign push    = uart_en & mem_wr_en & (reg_off == UART_TXDATA_OFF);
  assign stat_wr = uart_en & mem_wr_en & (reg_off == UART_STATUS_OFF);
  assign ovf_set = push & fifo_full & ~pop;
  assign ovf_d   = ovf_set | (ovf_q & ~stat_wr);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(mem_wr_data[7:0]),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    status_word                      = '0;
    status_word[STAT_CNT +: CNT_W]   = fifo_count;
    status_word[STAT_OVF]            = ovf_q;
    status_word[STAT_BUSY]           = busy_q;
    status_word[STAT_EMPTY]          = fifo_empty;
    status_word[STAT_FULL]           = fifo_full;
    rd_d = rd_q;
    if (uart_en & mem_rd_en) begin
      rd_d = (reg_off == UART_STATUS_OFF) ? status_word : '0;
    end
  end

  // Next-state logic; line level is derived from the next state so uart_tx is a clean flop output.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = BAUD_RELOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
    end
  end

  assign uart_tx     = tx_q;
  assign tx_busy     = busy_q;
  assign mem_rd_data = rd_q;

endmodule
